// File: rtl/mp3_pc_key_pio_if.sv
// Avalon-MM slave bus bundle for the front-panel key input port.
// Ports: address, chipselect, write_n, writedata in; readdata out.
interface mp3_pc_key_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/mp3_pc_key_pio.sv
// MP3 front-panel key PIO: sync, debounce, press capture, masked irq.
// Ports: clk, reset (sync, high), bus (Avalon slave), key_n, irq.
module mp3_pc_key_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  mp3_pc_key_pio_if.slave  bus,
  input  logic [WIDTH-1:0] key_n,
  output logic             irq
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_nx;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_cap_nx;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] irq_mask_nx;
  logic [WIDTH-1:0] clr;
  logic [CNT_W-1:0] cnt    [WIDTH];
  logic [CNT_W-1:0] cnt_nx [WIDTH];
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata_q;
  logic             unused_wd;

  assign unused_wd = ^bus.writedata;
  assign wr_en = bus.chipselect & ~bus.write_n;

  always_comb begin
    stable_nx = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nx[i] = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == LAST)
          stable_nx[i] = s2[i];
        else
          cnt_nx[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // a press on the clearing edge survives the clear
  always_comb begin
    irq_mask_nx = irq_mask;
    clr         = '0;
    if (wr_en && bus.address == 2'd2)
      irq_mask_nx = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == 2'd3)
      clr = bus.writedata[WIDTH-1:0];
    edge_cap_nx = (edge_cap & ~clr)
                | (stable_nx & ~stable);
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus.address)
      2'd0: rd_mux[WIDTH-1:0] = stable;
      2'd1: rd_mux = '0;
      2'd2: rd_mux[WIDTH-1:0] = irq_mask;
      2'd3: rd_mux[WIDTH-1:0] = edge_cap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= '0;
      s2         <= '0;
      stable     <= '0;
      edge_cap   <= '0;
      irq_mask   <= '0;
      readdata_q <= '0;
      irq        <= 1'b0;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      s1       <= ~key_n;
      s2       <= s1;
      stable   <= stable_nx;
      edge_cap <= edge_cap_nx;
      irq_mask <= irq_mask_nx;
      irq      <= |(edge_cap_nx & irq_mask_nx);
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= cnt_nx[i];
      if (bus.chipselect)
        readdata_q <= rd_mux;
    end
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_mp3_pc_key_pio.sv
// Bench for mp3_pc_key_pio: directed table, corner sequences, random.
// Random phase checked against a window-based debounce model.
module tb_mp3_pc_key_pio;

  localparam int W = 4;
  localparam int D = 4;
  localparam int HMAX = 8192;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] key_n;
  logic         irq;

  mp3_pc_key_pio_if bus();

  mp3_pc_key_pio #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .key_n(key_n),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: pressed history through the sync chain
  logic [W-1:0] s1h [HMAX];
  logic [W-1:0] s2h [HMAX];
  int           lc  [W];
  logic [W-1:0] m_st;
  logic [W-1:0] m_ec;
  logic [W-1:0] m_mask;
  logic [31:0]  m_rd;
  logic         m_irq;
  int           k = 0;

  typedef struct {
    logic        r;
    logic [3:0]  kn;
    logic        c;
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] erd;
    logic        eirq;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d: got %h expected %h",
               nm, k, act, exp);
    end
  endtask

  // stable[i] flips once s2[i] has differed from it on each of the
  // last D edges, all of them after its previous change or reset
  task automatic m_edge(input logic r, input logic [W-1:0] kn,
                        input logic c, input logic w,
                        input logic [1:0] a, input logic [31:0] d);
    logic [W-1:0] ns;
    logic [W-1:0] clr;
    bit ok;
    if (r) begin
      s1h[k] = '0;
      s2h[k] = '0;
      m_st = '0;
      m_ec = '0;
      m_mask = '0;
      m_rd = '0;
      m_irq = 1'b0;
      for (int i = 0; i < W; i++) lc[i] = k;
    end else begin
      s1h[k] = ~kn;
      s2h[k] = (k > 0) ? s1h[k-1] : '0;
      ns = m_st;
      for (int i = 0; i < W; i++) begin
        ok = 1;
        for (int j = k - D + 1; j <= k; j++) begin
          if (j <= lc[i]) ok = 0;
          else if (s2h[j-1][i] == m_st[i]) ok = 0;
        end
        if (ok) begin
          ns[i] = ~m_st[i];
          lc[i] = k;
        end
      end
      if (c) begin
        case (a)
          2'd0: m_rd = {28'd0, m_st};
          2'd1: m_rd = 32'd0;
          2'd2: m_rd = {28'd0, m_mask};
          default: m_rd = {28'd0, m_ec};
        endcase
      end
      clr = '0;
      if (c && !w && a == 2'd2) m_mask = d[W-1:0];
      if (c && !w && a == 2'd3) clr = d[W-1:0];
      m_ec = (m_ec & ~clr) | (ns & ~m_st);
      m_st = ns;
      m_irq = |(m_ec & m_mask);
    end
    k++;
  endtask

  task automatic cyc(input logic r, input logic [W-1:0] kn,
                     input logic c, input logic w,
                     input logic [1:0] a, input logic [31:0] d);
    reset = r;
    key_n = kn;
    bus.chipselect = c;
    bus.write_n = w;
    bus.address = a;
    bus.writedata = d;
    m_edge(r, kn, c, w, a, d);
    @(posedge clk);
    #1;
    chk("model_rd", bus.readdata, m_rd);
    chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic idle(input logic [W-1:0] kn, input int n);
    for (int i = 0; i < n; i++) cyc(0, kn, 0, 1, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [W-1:0] kn, input logic [1:0] a);
    cyc(0, kn, 1, 1, a, 32'hDEAD_BEEF);
  endtask

  task automatic wr(input logic [W-1:0] kn, input logic [1:0] a,
                    input logic [31:0] d);
    cyc(0, kn, 1, 0, a, d);
  endtask

  function automatic vec_t mk(logic r, logic [3:0] kn, logic c,
                              logic w, logic [1:0] a,
                              logic [31:0] erd, logic eirq);
    vec_t v;
    v.r = r; v.kn = kn; v.c = c; v.w = w;
    v.a = a; v.d = 32'hFFFF_FFFF;
    v.erd = erd; v.eirq = eirq;
    return v;
  endfunction

  initial begin
    logic [W-1:0] kn;
    logic r;

    // reset, register reads, then key0 press with exact latency
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 4'hF, 0, 1, 2'd0, 32'd0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 4'hF, 1, 1, 2'(i), 32'd0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 4'hE, 0, 1, 2'd0, 32'd0, 0));
    tbl.push_back(mk(0, 4'hE, 1, 1, 2'd0, 32'd0, 0));
    tbl.push_back(mk(0, 4'hE, 1, 1, 2'd0, 32'd1, 0));
    tbl.push_back(mk(0, 4'hE, 1, 1, 2'd3, 32'd1, 0));
    tbl.push_back(mk(0, 4'hE, 1, 1, 2'd1, 32'd0, 0));

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].kn, tbl[i].c, tbl[i].w,
          tbl[i].a, tbl[i].d);
      chk("tbl_rd", bus.readdata, tbl[i].erd);
      chk("tbl_irq", {31'd0, irq}, {31'd0, tbl[i].eirq});
    end

    // 3-cycle glitch on key1 is rejected
    idle(4'hC, 3);
    idle(4'hE, 6);
    rd(4'hE, 2'd3);
    chk("glitch_ec", bus.readdata, 32'h1);
    rd(4'hE, 2'd0);
    chk("glitch_st", bus.readdata, 32'h1);
    idle(4'hC, 7);
    rd(4'hC, 2'd3);
    chk("hold_ec", bus.readdata, 32'h3);

    // mask, write-0 no-op, clear
    wr(4'hC, 2'd3, 32'h1);
    wr(4'hC, 2'd2, 32'hFFFF_FFF2);
    chk("mask_irq", {31'd0, irq}, 32'd1);
    rd(4'hC, 2'd2);
    chk("mask_rd", bus.readdata, 32'h2);
    wr(4'hC, 2'd3, 32'h0);
    rd(4'hC, 2'd3);
    chk("w0_ec", bus.readdata, 32'h2);
    chk("w0_irq", {31'd0, irq}, 32'd1);
    wr(4'hC, 2'd3, 32'h2);
    chk("clr_irq", {31'd0, irq}, 32'd0);
    rd(4'hC, 2'd3);
    chk("clr_ec", bus.readdata, 32'h0);

    // clear write on the same edge stable[2] rises
    wr(4'hC, 2'd2, 32'h4);
    idle(4'h8, 5);
    wr(4'h8, 2'd3, 32'hF);
    chk("coll_irq", {31'd0, irq}, 32'd1);
    rd(4'h8, 2'd3);
    chk("coll_ec", bus.readdata, 32'h4);

    // release of key0 captures nothing
    idle(4'h9, 5);
    rd(4'h9, 2'd0);
    chk("rel_pre", bus.readdata, 32'h7);
    rd(4'h9, 2'd0);
    chk("rel_st", bus.readdata, 32'h6);
    rd(4'h9, 2'd3);
    chk("rel_ec", bus.readdata, 32'h4);

    // reset mid-count forces a full debounce afterwards
    idle(4'h7, 4);
    cyc(1, 4'h7, 0, 1, 2'd0, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    idle(4'h7, 5);
    rd(4'h7, 2'd0);
    chk("rst_pre", bus.readdata, 32'h0);
    rd(4'h7, 2'd0);
    chk("rst_st", bus.readdata, 32'h8);
    rd(4'h7, 2'd3);
    chk("rst_ec", bus.readdata, 32'h8);

    // random traffic against the model
    kn = 4'h7;
    for (int n = 0; n < 2000; n++) begin
      r = ($urandom % 400) == 0;
      if (($urandom % 6) == 0)
        kn = kn ^ W'(1 << ($urandom % W));
      cyc(r, kn, 1'($urandom % 2), ($urandom % 3) != 0,
          2'($urandom % 4), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
